// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame width and default bit divider.
package uart_pkg;

    localparam int DATA_BITS            = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 868;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Byte handshake between the UART receiver (master) and its consumer (slave).
interface uart_rx_if;
    import uart_pkg::*;

    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;

    modport master (output rx_data, output rx_valid, input rx_ready);
    modport slave  (input rx_data, input rx_valid, output rx_ready);

endinterface

// File: rtl/sync_ff.sv
// Flop-chain synchronizer for an asynchronous input; resets to 1 so an idle-high line
// does not look like an edge when reset releases.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, one-entry holding register,
// framing-error pulse and sticky overrun flag.
//
// state    | meaning
// ST_IDLE  | line idle, waiting for a falling start edge
// ST_START | counting to mid start bit to reject glitches
// ST_DATA  | sampling eight data bits, LSB first
// ST_STOP  | sampling the stop bit, delivering the byte
// ST_BREAK | stop bit was low; waiting for the line to return high
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int SYNC_STAGES  = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      UART_Rx,
    uart_rx_if.master rx_if,
    output logic      rx_busy,
    output logic      frame_err,
    output logic      overrun
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_M1   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    logic                 rx_s;
    rx_state_e            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 overrun_q, overrun_d;
    logic                 frame_err_q, frame_err_d;
    logic                 xfer;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (UART_Rx),
        .q   (rx_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = valid_q;
        overrun_d   = overrun_q;
        frame_err_d = 1'b0;
        xfer        = valid_q & rx_if.rx_ready;

        if (xfer) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                end
            end
            ST_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rx_s ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (cnt_q == BIT_M1) begin
                    cnt_d              = '0;
                    shift_d[bit_idx_q] = rx_s;
                    if (bit_idx_q == LAST_IDX) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (cnt_q == BIT_M1) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        state_d = ST_IDLE;
                        // A same-cycle transfer frees the slot, so the new byte is not an overrun.
                        if (!valid_q || xfer) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_BREAK: begin
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        rx_busy         = (state_q != ST_IDLE);
        frame_err       = frame_err_q;
        overrun         = overrun_q;
        rx_if.rx_data   = data_q;
        rx_if.rx_valid  = valid_q;
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit: bit-banged frames, handshake monitor,
// hand-computed expected bytes, flags and latency.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int CPB = 16;

    logic clk;
    logic rst;
    logic line;
    logic rx_busy;
    logic frame_err;
    logic overrun;

    uart_rx_if rx_if ();

    uart_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .UART_Rx   (line),
        .rx_if     (rx_if),
        .rx_busy   (rx_busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    int start_cyc;
    int rise_cyc;
    int valid_cycles;
    int ferr_cnt;
    logic valid_prev = 1'b0;
    logic [7:0] got[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (rx_if.rx_valid && rx_if.rx_ready) got.push_back(rx_if.rx_data);
            if (rx_if.rx_valid && !valid_prev) rise_cyc = cyc;
            if (rx_if.rx_valid) valid_cycles++;
            if (frame_err) ferr_cnt++;
        end
        valid_prev = rx_if.rx_valid;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] got_at(input int i);
        if (i < got.size()) return {24'h0, got[i]};
        return 32'hDEAD;
    endfunction

    task automatic clear_mon();
        got.delete();
        valid_cycles = 0;
        ferr_cnt     = 0;
    endtask

    task automatic drive_bit(input logic v);
        @(posedge clk);
        #1 line = v;
        repeat (CPB - 1) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_val);
        @(posedge clk);
        #1 line = 1'b0;
        start_cyc = cyc;
        repeat (CPB - 1) @(posedge clk);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_val);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        line = 1'b1;
        rx_if.rx_ready = 1'b1;
        rise_cyc = 0;
        clear_mon();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", rx_if.rx_valid, 0);
        chk("rst_data", rx_if.rx_data, 8'h00);
        chk("rst_busy", rx_busy, 0);
        chk("rst_ovr", overrun, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        idle(4);

        // single byte with latency check
        clear_mon();
        send_frame(8'hA5, 1'b1);
        idle(10);
        chk("a5_count", got.size(), 1);
        chk("a5_data", got_at(0), 8'hA5);
        chk("a5_latency", rise_cyc - start_cyc, 155);
        chk("a5_valid_len", valid_cycles, 1);
        chk("a5_ferr", ferr_cnt, 0);
        chk("a5_ovr", overrun, 0);

        // back-to-back frames, no idle gap
        clear_mon();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h55, 1'b1);
        idle(10);
        chk("b2b_count", got.size(), 3);
        chk("b2b_0", got_at(0), 8'h00);
        chk("b2b_1", got_at(1), 8'hFF);
        chk("b2b_2", got_at(2), 8'h55);
        chk("b2b_ferr", ferr_cnt, 0);

        // short low glitch is rejected at mid start bit
        clear_mon();
        @(posedge clk);
        #1 line = 1'b0;
        idle(5);
        chk("glitch_busy_mid", rx_busy, 1);
        @(posedge clk);
        #1 line = 1'b1;
        idle(12);
        chk("glitch_busy", rx_busy, 0);
        chk("glitch_valid", rx_if.rx_valid, 0);
        chk("glitch_ferr", ferr_cnt, 0);
        chk("glitch_count", got.size(), 0);

        // framing error then held-low line, then recovery
        clear_mon();
        send_frame(8'h3C, 1'b0);
        idle(100);
        chk("brk_busy", rx_busy, 1);
        line = 1'b1;
        idle(2 * CPB);
        chk("brk_idle", rx_busy, 0);
        chk("brk_ferr", ferr_cnt, 1);
        chk("brk_nobyte", got.size(), 0);
        send_frame(8'h81, 1'b1);
        idle(10);
        chk("brk_next_count", got.size(), 1);
        chk("brk_next_data", got_at(0), 8'h81);
        chk("brk_next_ferr", ferr_cnt, 1);

        // overrun with consumer stalled
        clear_mon();
        rx_if.rx_ready = 1'b0;
        send_frame(8'h11, 1'b1);
        idle(5);
        chk("ovr_first_valid", rx_if.rx_valid, 1);
        chk("ovr_first_flag", overrun, 0);
        send_frame(8'h22, 1'b1);
        idle(10);
        chk("ovr_valid", rx_if.rx_valid, 1);
        chk("ovr_data", rx_if.rx_data, 8'h11);
        chk("ovr_flag", overrun, 1);
        @(posedge clk);
        #1 rx_if.rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_if.rx_ready = 1'b0;
        chk("ovr_clr_valid", rx_if.rx_valid, 0);
        chk("ovr_clr_flag", overrun, 0);
        chk("ovr_xfer", got_at(0), 8'h11);
        rx_if.rx_ready = 1'b1;
        idle(4);

        // reset in the middle of a data bit, then a clean frame
        clear_mon();
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        idle(2);
        chk("mid_rst_busy", rx_busy, 0);
        chk("mid_rst_valid", rx_if.rx_valid, 0);
        chk("mid_rst_data", rx_if.rx_data, 8'h00);
        chk("mid_rst_ferr", frame_err, 0);
        line = 1'b1;
        rst = 1'b0;
        idle(200);
        chk("mid_rst_nobyte", got.size(), 0);
        chk("mid_rst_noferr", ferr_cnt, 0);
        send_frame(8'h5A, 1'b1);
        idle(10);
        chk("after_rst_count", got.size(), 1);
        chk("after_rst_data", got_at(0), 8'h5A);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver; consumes the serial line driven by the project's UART transmitter (loopback or external pin).
- 8N1 frames, LSB first, idle-high line, fixed integer clocks-per-bit divider.
- Presents each received byte through a one-entry holding register with valid/ready handshake.
- Flags framing errors and overruns.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per bit period (100 MHz / 115200); legal range 4..65535.
- SYNC_STAGES, 2, flip-flop stages of the input synchronizer; legal range 2..3.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- UART_Rx  input  1  asynchronous serial line, idle high.
- rx_data  output  8  received byte; stable while rx_valid=1.
- rx_valid  output  1  holding register full.
- rx_ready  input  1  consumer accepts; a transfer occurs on a cycle with rx_valid&rx_ready.
- rx_busy  output  1  high in any state other than IDLE.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  sticky; a byte was lost because the holding register was full.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; rx_data=8'h00; rx_valid=0; rx_busy=0; frame_err=0; overrun=0; synchronizer flops=1; counters=0. Reset has priority over everything and aborts any frame in progress.
- Synchronizer: UART_Rx passes through SYNC_STAGES flops to give rx_s. All decisions use rx_s. A line edge reaches rx_s SYNC_STAGES cycles later.
- Bit counter: cnt, width $clog2(CLKS_PER_BIT). HALF = CLKS_PER_BIT/2, integer floor.
- IDLE:
  - rx_s=0 → START, cnt=0.
- START:
  - cnt counts to HALF-1, then rx_s is sampled.
  - Sample 0 → DATA, cnt=0, bit_idx=0.
  - Sample 1 → false start (glitch): back to IDLE, no flags raised.
- DATA:
  - At cnt=CLKS_PER_BIT-1, sample rx_s into shift[bit_idx] (LSB first) and reset cnt.
  - After bit_idx=7 → STOP.
- STOP:
  - At cnt=CLKS_PER_BIT-1, sample rx_s.
  - Sample 1 (good frame), holding register empty: rx_data<=shift and rx_valid<=1 on the next edge; go to IDLE.
  - Sample 1 (good frame), holding register full and not accepted that cycle: old rx_data kept, new byte dropped, overrun<=1; go to IDLE.
  - Sample 1 (good frame), holding register full but rx_valid&rx_ready in the same cycle: the new byte is loaded and rx_valid stays 1. Not an overrun.
  - Sample 0: frame_err pulses for 1 cycle, no byte is delivered, go to BREAK.
- BREAK:
  - Stay until rx_s=1, then → IDLE. Prevents a held-low line from re-triggering.
- Handshake:
  - rx_valid falls on the edge after rx_valid&rx_ready, unless a new byte loads at the same edge.
  - rx_ready is ignored while rx_valid=0.
- overrun: cleared only by rst or by a completed handshake (the transfer clears it on the same edge).
- Latency: from the falling start edge on UART_Rx to rx_valid=1 is SYNC_STAGES + HALF + 9·CLKS_PER_BIT + 1 cycles.
- Back-to-back frames: a start edge arriving immediately after the mid-stop sample is detected normally, because IDLE is re-entered right at mid-stop.
- rx_busy = (state != IDLE).

Decomposition:
- Shared package uart_pkg:
  - state encoding constants ST_IDLE, ST_START, ST_DATA, ST_STOP, ST_BREAK (3 bits).
  - DATA_BITS=8.
  - Default CLKS_PER_BIT, shared with the transmitter.
- One natural sub-module: sync_ff. A parameterized SYNC_STAGES flop chain with reset value 1, reusable for other asynchronous inputs.
- The FSM, counters and holding register stay in uart_rx.

Test Plan (CLKS_PER_BIT=16, SYNC_STAGES=2, 100 MHz clk, rx_ready=1 unless stated):
- Send 8'hA5, 8N1 → rx_data=8'hA5 and rx_valid high for exactly 1 cycle, 2+8+144+1=155 cycles after the start edge; frame_err=0, overrun=0.
- Back-to-back 8'h00, 8'hFF, 8'h55 with no idle gap → three valid pulses carrying those values in order, no errors.
- 6-cycle low glitch on an idle line → returns to IDLE; rx_valid, frame_err and rx_busy all 0 after about 10 cycles.
- Send 8'h3C with the stop bit forced low, then hold the line low for 100 cycles, then release and send 8'h81 → one frame_err pulse, no valid for 8'h3C, next byte 8'h81 received correctly.
- rx_ready=0; send 8'h11 then 8'h22 → rx_valid stays 1, rx_data=8'h11, overrun=1; raising rx_ready for one cycle clears rx_valid and overrun.
- Assert rst mid-DATA while sending 8'hC3, release, then send 8'h5A → outputs at reset values during rst, no valid for the partial byte, 8'h5A received cleanly.
